// File: rtl/sample_fetch_ctrl.sv
// Sample fetch sequencer: walks [base, base+num) once per epoch, registering memory data onto a
// valid/ready stream. Define SAMPLE_FETCH_ABORT_EN to add the abort input and aborted status output.
`ifndef IN_DIM
`define IN_DIM 4
`endif
`ifndef IN_ENTRY_W
`define IN_ENTRY_W 8
`endif

module sample_fetch_ctrl #(
    parameter int SAMPLE_CNT = 10000,
    parameter int EPOCH_W    = 8,
    parameter int DATA_W     = `IN_DIM * `IN_ENTRY_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [31:0]        base_addr,
    input  logic [31:0]        num_samples,
    input  logic [EPOCH_W-1:0] num_epochs,
    output logic [31:0]        mem_address,
    input  logic [DATA_W-1:0]  mem_data,
    output logic [DATA_W-1:0]  sample_data,
    output logic               sample_valid,
    input  logic               sample_ready,
    output logic [31:0]        sample_idx,
    output logic [EPOCH_W-1:0] epoch_idx,
    output logic               sample_last,
    output logic               busy,
    output logic               done,
`ifdef SAMPLE_FETCH_ABORT_EN
    input  logic               abort,
    output logic               aborted,
`endif
    output logic               err
);

    localparam int          ISSUE_W     = 32 + EPOCH_W;
    localparam logic [32:0] SAMPLE_CNT_X = 33'(SAMPLE_CNT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [31:0]          mem_address_q, mem_address_d;
    logic [31:0]          base_q, base_d;
    logic [31:0]          last_addr_q, last_addr_d;
    logic [ISSUE_W-1:0]   issues_left_q, issues_left_d;
    logic [EPOCH_W-1:0]   issue_epoch_q, issue_epoch_d;
    logic [DATA_W-1:0]    sample_data_q, sample_data_d;
    logic                 sample_valid_q, sample_valid_d;
    logic [31:0]          sample_idx_q, sample_idx_d;
    logic [EPOCH_W-1:0]   epoch_idx_q, epoch_idx_d;
    logic                 sample_last_q, sample_last_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic                 abort_s;
    logic                 illegal_s;
    logic                 load_en_s;
    logic                 start_acc_s;

`ifdef SAMPLE_FETCH_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    // Bound check is widened to 33 bits so base+num cannot wrap into the legal range.
    assign illegal_s   = (num_samples == 32'd0) || (num_epochs == '0) ||
                         (({1'b0, base_addr} + {1'b0, num_samples}) > SAMPLE_CNT_X);
    assign start_acc_s = (state_q == ST_IDLE) && start;
    assign load_en_s   = (state_q == ST_STREAM) && (!sample_valid_q || sample_ready) &&
                         (issues_left_q != '0);

    // Next-state and datapath update for the fetch sequencer.
    always_comb begin
        state_d        = state_q;
        mem_address_d  = mem_address_q;
        base_d         = base_q;
        last_addr_d    = last_addr_q;
        issues_left_d  = issues_left_q;
        issue_epoch_d  = issue_epoch_q;
        sample_data_d  = sample_data_q;
        sample_valid_d = sample_valid_q;
        sample_idx_d   = sample_idx_q;
        epoch_idx_d    = epoch_idx_q;
        sample_last_d  = sample_last_q;
        err_d          = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    err_d         = 1'b0;
                    sample_last_d = 1'b0;
                    if (illegal_s) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        base_d        = base_addr;
                        last_addr_d   = base_addr + num_samples - 32'd1;
                        mem_address_d = base_addr;
                        issues_left_d = ISSUE_W'(num_samples) * ISSUE_W'(num_epochs);
                        issue_epoch_d = '0;
                        state_d       = ST_STREAM;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (abort_s) begin
                    sample_valid_d = 1'b0;
                    state_d        = ST_DONE;
                end else if (load_en_s) begin
                    sample_data_d  = mem_data;
                    sample_idx_d   = mem_address_q;
                    epoch_idx_d    = issue_epoch_q;
                    sample_last_d  = (issues_left_q == ISSUE_W'(1));
                    sample_valid_d = 1'b1;
                    issues_left_d  = issues_left_q - ISSUE_W'(1);
                    // The last index of the range wraps back to base and opens the next epoch.
                    if (mem_address_q == last_addr_q) begin
                        mem_address_d = base_q;
                        issue_epoch_d = issue_epoch_q + EPOCH_W'(1);
                    end else begin
                        mem_address_d = mem_address_q + 32'd1;
                    end
                    if (issues_left_q == ISSUE_W'(1)) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_STREAM;
                    end
                end else begin
                    state_d = ST_STREAM;
                end
            end
            ST_DRAIN: begin
                if (abort_s) begin
                    sample_valid_d = 1'b0;
                    state_d        = ST_DONE;
                end else if (sample_valid_q && sample_ready) begin
                    sample_valid_d = 1'b0;
                    state_d        = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d        = ST_IDLE;
                sample_valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d == ST_STREAM) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            mem_address_q  <= 32'd0;
            base_q         <= 32'd0;
            last_addr_q    <= 32'd0;
            issues_left_q  <= '0;
            issue_epoch_q  <= '0;
            sample_data_q  <= '0;
            sample_valid_q <= 1'b0;
            sample_idx_q   <= 32'd0;
            epoch_idx_q    <= '0;
            sample_last_q  <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            mem_address_q  <= mem_address_d;
            base_q         <= base_d;
            last_addr_q    <= last_addr_d;
            issues_left_q  <= issues_left_d;
            issue_epoch_q  <= issue_epoch_d;
            sample_data_q  <= sample_data_d;
            sample_valid_q <= sample_valid_d;
            sample_idx_q   <= sample_idx_d;
            epoch_idx_q    <= epoch_idx_d;
            sample_last_q  <= sample_last_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            err_q          <= err_d;
        end
    end

`ifdef SAMPLE_FETCH_ABORT_EN
    logic aborted_q, aborted_d;

    // Abort status: set by an abort that lands while streaming, cleared by the next accepted start.
    always_comb begin
        aborted_d = aborted_q;
        if (start_acc_s) begin
            aborted_d = 1'b0;
        end else if (abort_s && ((state_q == ST_STREAM) || (state_q == ST_DRAIN))) begin
            aborted_d = 1'b1;
        end else begin
            aborted_d = aborted_q;
        end
    end

    // Abort status register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= aborted_d;
        end
    end

    assign aborted = aborted_q;
`else
    logic unused_start_acc_s;
    assign unused_start_acc_s = start_acc_s;
`endif

    assign mem_address  = mem_address_q;
    assign sample_data  = sample_data_q;
    assign sample_valid = sample_valid_q;
    assign sample_idx   = sample_idx_q;
    assign epoch_idx    = epoch_idx_q;
    assign sample_last  = sample_last_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: doc/sample_fetch_ctrl.md
Name: sample_fetch_ctrl

Overview:
Sequencer that streams training/inference samples out of the sample memory into the compute datapath. It drives the memory's combinational read address and registers each returned sample vector. It presents samples on a valid/ready stream. Accepts a start command with base index, sample count and epoch count, walks the range once per epoch, and signals completion.

Parameters:
SAMPLE_CNT, 10000, number of valid sample entries in memory; the legal index range is 0..SAMPLE_CNT-1.
EPOCH_W, 8, width of the epoch count and epoch index.
DATA_W, `IN_DIM*`IN_ENTRY_W, width of one flattened sample vector; entry j occupies bits [`IN_ENTRY_W*(j+1)-1 : `IN_ENTRY_W*j].

Ports:
clk  input  1  single clock, all state on rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  command pulse; accepted only in IDLE.
base_addr  input  32  first sample index, sampled on accepted start.
num_samples  input  32  samples per epoch, sampled on accepted start.
num_epochs  input  EPOCH_W  passes over the range, sampled on accepted start.
mem_address  output  32  read address to sample memory; memory returns data in the same cycle.
mem_data  input  DATA_W  flattened sample vector for mem_address.
sample_data  output  DATA_W  registered sample.
sample_valid  output  1  sample_data valid.
sample_ready  input  1  downstream accepts when valid&&ready.
sample_idx  output  32  memory index of sample_data.
epoch_idx  output  EPOCH_W  epoch of sample_data, 0-based.
sample_last  output  1  sample_data is last of the final epoch.
busy  output  1  high in STREAM and DRAIN.
done  output  1  one-cycle pulse at completion.
err  output  1  sticky until next accepted start; set on illegal command.

Behaviour:
- Reset (async, rst_n=0): state IDLE; mem_address=0, sample_data=0, sample_valid=0, sample_idx=0, epoch_idx=0, sample_last=0, busy=0, done=0, err=0; all counters 0.
- States: IDLE, STREAM, DRAIN, DONE.
- IDLE: start=1 latches base/count/epochs and clears err. Illegal if num_samples==0, num_epochs==0, or base_addr+num_samples>SAMPLE_CNT. Compute the bound check in 33 bits, with no wrap. Illegal -> DONE with err=1, no samples emitted. Legal -> STREAM with mem_address=base_addr and remaining = num_samples*num_epochs issues.
- STREAM: load_en = (!sample_valid || sample_ready) && issues_left>0. On load_en: sample_data<=mem_data, sample_idx<=mem_address, epoch_idx<=issue epoch, sample_last<=(final issue), sample_valid<=1. mem_address then advances by +1. At base_addr+num_samples-1 it wraps to base_addr and the issue epoch increments. When the final issue loads -> DRAIN.
- Throughput is 1 sample/clk while sample_ready=1. Latency is start accepted at edge N -> first sample_valid after edge N+1.
- sample_valid && !sample_ready: all output fields hold stable and mem_address holds.
- DRAIN: wait for valid&&ready on the last sample. Then sample_valid<=0 -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE. busy=0 in IDLE and DONE.
- start in any state other than IDLE is ignored, with no effect on latched parameters.
- Reset asserted mid-stream aborts immediately; no done pulse is produced.

Optional Feature:
Macro SAMPLE_FETCH_ABORT_EN.
- With the macro: extra input port abort (1 bit). abort=1 in STREAM or DRAIN clears sample_valid on the next edge, discarding any held sample, and goes to DONE. done pulses with err=0, and the extra output aborted=1 stays set until the next accepted start. abort is ignored in IDLE and DONE.
- Without the macro: neither port exists and streams always run to completion.

Test Plan:
- Legal run: base=5, num=3, epochs=2, ready=1 -> sample_idx sequence 5,6,7,5,6,7 on consecutive cycles; epoch_idx 0,0,0,1,1,1; sample_last only on the 6th; done pulses one cycle after the last handshake; each sample_data matches memory entry.
- Backpressure: base=0, num=4, epochs=1, ready toggling 1,0,0,1,... -> sample_data and sample_idx stable while ready=0; no index skipped or duplicated; 4 handshakes total.
- Illegal command: base=9998, num=3 with SAMPLE_CNT=10000 -> no sample_valid, done pulse, err=1. A following legal start clears err.
- Boundary: base=9999, num=1, epochs=3 -> three samples, all with idx 9999; mem_address never exceeds 9999.
- Start while busy plus async reset: a second start with different base mid-stream is ignored. Dropping rst_n mid-stream clears all outputs within the same cycle and returns to IDLE with no done pulse.
- (SAMPLE_FETCH_ABORT_EN) abort asserted after 2 of 10 samples with ready=0 -> sample_valid falls next edge, done pulses, aborted=1, err=0.
